// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board size, piece codes, controller state encoding
// and the LFSR-to-piece draw mapping. Used by the piece controller, board store and display.
package tetris_pkg;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 20;
  localparam int SPAWN_X_DEF = 3;
  localparam int SPAWN_Y_DEF = 0;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPAWN    = 3'd1,
    ST_FALL     = 3'd2,
    ST_LOCK     = 3'd3,
    ST_WAIT_REF = 3'd4,
    ST_OVER     = 3'd5,
    ST_HARD     = 3'd6
  } state_t;

  // Code 7 is not a piece: fall back to the next three bits, then to 0.
  function automatic logic [2:0] lfsr_draw(input logic [7:0] lfsr);
    if (lfsr[2:0] != 3'd7)      return lfsr[2:0];
    else if (lfsr[5:3] != 3'd7) return lfsr[5:3];
    else                        return 3'd0;
  endfunction

endpackage

// File: rtl/piece_ctrl_if.sv
// Link between the piece controller (master) and the board store (slave):
// active piece position/shape out, combinational move enables and lock handshake back.
interface piece_ctrl_if;
  logic [4:0] x;
  logic [4:0] y;
  logic [2:0] piece_type;
  logic [1:0] dir;
  logic       refresh;
  logic       el;
  logic       er;
  logic       eu;
  logic       edrop;
  logic       overflow;
  logic       refresh_done;

  modport master (
    output x, y, piece_type, dir, refresh,
    input  el, er, eu, edrop, overflow, refresh_done
  );

  modport slave (
    input  x, y, piece_type, dir, refresh,
    output el, er, eu, edrop, overflow, refresh_done
  );
endinterface

// File: rtl/piece_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with its piece draw mapping.
module piece_lfsr
  import tetris_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [2:0] o_draw
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk) begin
    if (!rstn) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign o_draw = lfsr_draw(r_lfsr);

endmodule

// File: rtl/piece_ctrl.sv
// Falling-piece controller: gravity, player moves, lock handshake and spawning.
// Optional hard drop (btn_hard input, HARD state) is built when HARD_DROP_EN is defined.
module piece_ctrl
  import tetris_pkg::*;
#(
  parameter int         DROP_TICKS = 25_000_000,
  parameter int         SPAWN_X    = SPAWN_X_DEF,
  parameter int         SPAWN_Y    = SPAWN_Y_DEF,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_rot,
  input  logic        btn_down,
`ifdef HARD_DROP_EN
  input  logic        btn_hard,
`endif
  piece_ctrl_if.master brd,
  output logic [2:0]  next_type,
  output logic        playing,
  output logic        game_over
);

  localparam int             CW        = (DROP_TICKS > 2) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(DROP_TICKS - 1);
  localparam logic [4:0]     X0        = 5'(SPAWN_X);
  localparam logic [4:0]     Y0        = 5'(SPAWN_Y);

  state_t        r_state, w_state;
  logic [4:0]    r_x, w_x, r_y, w_y;
  logic [2:0]    r_type, w_type, r_next_type, w_next_type;
  logic [1:0]    r_dir, w_dir;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_game_over, w_game_over;
  logic          r_need_next, w_need_next;
  logic [2:0]    w_draw;
  logic          w_tick;

  piece_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rstn   (rstn),
    .o_draw (w_draw)
  );

  assign w_tick = (r_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_x         <= X0;
      r_y         <= Y0;
      r_type      <= 3'd0;
      r_dir       <= 2'd0;
      r_next_type <= 3'd0;
      r_cnt       <= '0;
      r_game_over <= 1'b0;
      r_need_next <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_x         <= w_x;
      r_y         <= w_y;
      r_type      <= w_type;
      r_dir       <= w_dir;
      r_next_type <= w_next_type;
      r_cnt       <= w_cnt;
      r_game_over <= w_game_over;
      r_need_next <= w_need_next;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_x         = r_x;
    w_y         = r_y;
    w_type      = r_type;
    w_dir       = r_dir;
    w_next_type = r_next_type;
    w_cnt       = r_cnt;
    w_game_over = r_game_over;
    w_need_next = r_need_next;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_type      = w_draw;
          w_need_next = 1'b1;
          w_x         = X0;
          w_y         = Y0;
          w_dir       = 2'd0;
          w_state     = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        // The preview is drawn here only for the first piece of a game, so
        // type and next_type come from two different LFSR states.
        if (r_need_next) begin
          w_next_type = w_draw;
          w_need_next = 1'b0;
        end
        if (brd.overflow) begin
          w_game_over = 1'b1;
          w_state     = ST_OVER;
        end else begin
          w_cnt   = '0;
          w_state = ST_FALL;
        end
      end
      ST_FALL: begin
        w_cnt = w_tick ? '0 : r_cnt + 1'b1;
`ifdef HARD_DROP_EN
        if (btn_hard) begin
          w_state = ST_HARD;
        end else
`endif
        if (w_tick || btn_down) begin
          if (brd.edrop) begin
            w_y   = r_y + 5'd1;
            w_cnt = '0;
          end else begin
            w_state = ST_LOCK;
          end
        end else if (btn_rot && brd.eu) begin
          w_dir = r_dir + 2'd1;
        end else if (btn_l && brd.el) begin
          w_x = r_x - 5'd1;
        end else if (btn_r && brd.er) begin
          w_x = r_x + 5'd1;
        end
      end
      ST_LOCK: begin
        w_state = ST_WAIT_REF;
      end
      ST_WAIT_REF: begin
        if (brd.refresh_done) begin
          w_type      = r_next_type;
          w_next_type = w_draw;
          w_x         = X0;
          w_y         = Y0;
          w_dir       = 2'd0;
          w_state     = ST_SPAWN;
        end
      end
      ST_OVER: begin
      end
`ifdef HARD_DROP_EN
      ST_HARD: begin
        if (brd.edrop) w_y = r_y + 5'd1;
        else           w_state = ST_LOCK;
      end
`endif
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign brd.x          = r_x;
  assign brd.y          = r_y;
  assign brd.piece_type = r_type;
  assign brd.dir        = r_dir;
  assign brd.refresh    = (r_state == ST_LOCK);
  assign next_type      = r_next_type;
  assign game_over      = r_game_over;
  assign playing        = r_state inside {ST_SPAWN, ST_FALL, ST_LOCK, ST_WAIT_REF, ST_HARD};

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl with DROP_TICKS=4; the board store is played by the bench.
// Hard-drop scenario is included when HARD_DROP_EN is defined.
module tb_piece_ctrl;

  logic       clk = 1'b0;
  logic       rstn, start, btn_l, btn_r, btn_rot, btn_down, btn_hard;
  logic [2:0] next_type;
  logic       playing, game_over;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_lfsr;
  logic [2:0] exp_type, exp_next, exp_nn;

  always #5 clk = ~clk;

  piece_ctrl_if brd();

  piece_ctrl #(.DROP_TICKS(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_rot   (btn_rot),
    .btn_down  (btn_down),
`ifdef HARD_DROP_EN
    .btn_hard  (btn_hard),
`endif
    .brd       (brd),
    .next_type (next_type),
    .playing   (playing),
    .game_over (game_over)
  );

  function automatic logic [7:0] f_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [2:0] f_draw(input logic [7:0] l);
    if (l[2:0] != 3'd7)      return l[2:0];
    else if (l[5:3] != 3'd7) return l[5:3];
    else                     return 3'd0;
  endfunction

  // Reference LFSR tracking the DUT's generator from reset
  always @(posedge clk) begin
    if (!rstn) m_lfsr <= 8'hA5;
    else       m_lfsr <= f_step(m_lfsr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; btn_l = 0; btn_r = 0; btn_rot = 0; btn_down = 0; btn_hard = 0;
    brd.el = 0; brd.er = 0; brd.eu = 0; brd.edrop = 0; brd.overflow = 0; brd.refresh_done = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    clear_inputs();
    cyc(); cyc();
    n_checks++; if (brd.x !== 5'd3) begin n_fail++; $display("FAIL reset_x: got %0d want 3", brd.x); end
    n_checks++; if (brd.y !== 5'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", brd.y); end
    n_checks++; if (brd.piece_type !== 3'd0) begin n_fail++; $display("FAIL reset_type: got %0d want 0", brd.piece_type); end
    n_checks++; if (brd.dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d want 0", brd.dir); end
    n_checks++; if (next_type !== 3'd0) begin n_fail++; $display("FAIL reset_next: got %0d want 0", next_type); end
    n_checks++; if (brd.refresh !== 1'b0) begin n_fail++; $display("FAIL reset_refresh: got %0b want 0", brd.refresh); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %0b want 0", game_over); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %0b want 0", playing); end
    $display("test_reset: x=%0d y=%0d type=%0d", brd.x, brd.y, brd.piece_type);
    rstn = 1;
  endtask

  task automatic test_gravity();
    brd.edrop = 1; brd.overflow = 0;
    start = 1;
    exp_type = f_draw(m_lfsr);
    cyc();
    start = 0;
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL spawn_playing: got %0b want 1", playing); end
    n_checks++; if (brd.piece_type !== exp_type) begin n_fail++; $display("FAIL start_type: got %0d want %0d", brd.piece_type, exp_type); end
    exp_next = f_draw(m_lfsr);
    cyc();
    n_checks++; if (next_type !== exp_next) begin n_fail++; $display("FAIL start_next: got %0d want %0d", next_type, exp_next); end
    n_checks++; if (brd.piece_type > 3'd6) begin n_fail++; $display("FAIL type_range: got %0d want <=6", brd.piece_type); end
    n_checks++; if (next_type > 3'd6) begin n_fail++; $display("FAIL next_range: got %0d want <=6", next_type); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (brd.y !== 5'd0) begin n_fail++; $display("FAIL gravity_wait%0d: y=%0d want 0", i, brd.y); end
    end
    cyc();
    n_checks++; if (brd.y !== 5'd1) begin n_fail++; $display("FAIL gravity_1: y=%0d want 1", brd.y); end
    repeat (3) cyc();
    n_checks++; if (brd.y !== 5'd1) begin n_fail++; $display("FAIL gravity_hold: y=%0d want 1", brd.y); end
    cyc();
    n_checks++; if (brd.y !== 5'd2) begin n_fail++; $display("FAIL gravity_2: y=%0d want 2", brd.y); end
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL fall_playing: got %0b want 1", playing); end
    $display("test_gravity: type=%0d next=%0d y=%0d", brd.piece_type, next_type, brd.y);
  endtask

  task automatic test_moves();
    btn_l = 1; brd.el = 1;
    cyc();
    btn_l = 0;
    n_checks++; if (brd.x !== 5'd2) begin n_fail++; $display("FAIL move_left: x=%0d want 2", brd.x); end
    btn_r = 1; brd.er = 0;
    cyc();
    btn_r = 0;
    n_checks++; if (brd.x !== 5'd2) begin n_fail++; $display("FAIL right_blocked: x=%0d want 2", brd.x); end
    $display("test_moves: x=%0d", brd.x);
  endtask

  task automatic test_down_priority();
    btn_down = 1; btn_l = 1; brd.el = 1;
    cyc();
    btn_down = 0; btn_l = 0;
    n_checks++; if (brd.y !== 5'd3) begin n_fail++; $display("FAIL down_y: y=%0d want 3", brd.y); end
    n_checks++; if (brd.x !== 5'd2) begin n_fail++; $display("FAIL down_drops_left: x=%0d want 2", brd.x); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (brd.y !== 5'd3) begin n_fail++; $display("FAIL down_cnt_clear%0d: y=%0d want 3", i, brd.y); end
    end
    cyc();
    n_checks++; if (brd.y !== 5'd4) begin n_fail++; $display("FAIL down_next_tick: y=%0d want 4", brd.y); end
    $display("test_down_priority: x=%0d y=%0d", brd.x, brd.y);
  endtask

  task automatic test_rotate();
    brd.eu = 1;
    for (int i = 1; i <= 3; i++) begin
      btn_rot = 1;
      cyc();
      n_checks++; if (brd.dir !== 2'(i)) begin n_fail++; $display("FAIL rot_%0d: dir=%0d want %0d", i, brd.dir, i); end
    end
    cyc(); // gravity tick outranks the rotate
    n_checks++; if (brd.dir !== 2'd3) begin n_fail++; $display("FAIL rot_vs_tick: dir=%0d want 3", brd.dir); end
    n_checks++; if (brd.y !== 5'd5) begin n_fail++; $display("FAIL tick_y: y=%0d want 5", brd.y); end
    cyc();
    n_checks++; if (brd.dir !== 2'd0) begin n_fail++; $display("FAIL rot_wrap: dir=%0d want 0", brd.dir); end
    brd.eu = 0;
    cyc();
    btn_rot = 0;
    n_checks++; if (brd.dir !== 2'd0) begin n_fail++; $display("FAIL rot_blocked: dir=%0d want 0", brd.dir); end
    btn_r = 1; brd.er = 1;
    cyc();
    btn_r = 0;
    n_checks++; if (brd.x !== 5'd3) begin n_fail++; $display("FAIL move_right: x=%0d want 3", brd.x); end
    $display("test_rotate: dir=%0d x=%0d y=%0d", brd.dir, brd.x, brd.y);
  endtask

  task automatic test_lock();
    brd.edrop = 0;
    cyc();
    n_checks++; if (brd.refresh !== 1'b1) begin n_fail++; $display("FAIL lock_refresh: got %0b want 1", brd.refresh); end
    n_checks++; if (brd.y !== 5'd5) begin n_fail++; $display("FAIL lock_y: y=%0d want 5", brd.y); end
    btn_l = 1; brd.el = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if (brd.refresh !== 1'b0) begin n_fail++; $display("FAIL wait_refresh%0d: got %0b want 0", i, brd.refresh); end
      n_checks++; if (brd.x !== 5'd3) begin n_fail++; $display("FAIL wait_hold_x%0d: x=%0d want 3", i, brd.x); end
    end
    btn_l = 0;
    brd.refresh_done = 1;
    exp_nn = f_draw(m_lfsr);
    cyc();
    brd.refresh_done = 0;
    n_checks++; if (brd.piece_type !== exp_next) begin n_fail++; $display("FAIL respawn_type: got %0d want %0d", brd.piece_type, exp_next); end
    n_checks++; if (next_type !== exp_nn) begin n_fail++; $display("FAIL respawn_next: got %0d want %0d", next_type, exp_nn); end
    n_checks++; if (brd.x !== 5'd3 || brd.y !== 5'd0 || brd.dir !== 2'd0) begin
      n_fail++; $display("FAIL respawn_pos: x=%0d y=%0d dir=%0d want 3 0 0", brd.x, brd.y, brd.dir);
    end
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL respawn_playing: got %0b want 1", playing); end
    $display("test_lock: type=%0d next=%0d", brd.piece_type, next_type);
  endtask

  task automatic test_game_over();
    brd.overflow = 1;
    cyc();
    brd.overflow = 0;
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_flag: got %0b want 1", game_over); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL over_playing: got %0b want 0", playing); end
    n_checks++; if (next_type !== exp_nn) begin n_fail++; $display("FAIL over_next_kept: got %0d want %0d", next_type, exp_nn); end
    start = 1; cyc(); start = 0;
    btn_l = 1; brd.el = 1; brd.edrop = 1; cyc(); btn_l = 0;
    brd.refresh_done = 1; cyc(); brd.refresh_done = 0;
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_sticky: got %0b want 1", game_over); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL over_ignores: playing=%0b want 0", playing); end
    n_checks++; if (brd.x !== 5'd3 || brd.piece_type !== exp_next) begin
      n_fail++; $display("FAIL over_frozen: x=%0d type=%0d want 3 %0d", brd.x, brd.piece_type, exp_next);
    end
    $display("test_game_over: game_over=%0b playing=%0b", game_over, playing);
  endtask

  task automatic test_reset_in_wait_ref();
    rstn = 0; clear_inputs(); cyc(); rstn = 1;
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL over_cleared: got %0b want 0", game_over); end
    brd.edrop = 1;
    start = 1; cyc(); start = 0;
    cyc();
    brd.edrop = 0; btn_down = 1; cyc(); btn_down = 0;
    n_checks++; if (brd.refresh !== 1'b1) begin n_fail++; $display("FAIL soft_lock_refresh: got %0b want 1", brd.refresh); end
    cyc();
    rstn = 0; cyc(); rstn = 1;
    n_checks++; if (playing !== 1'b0 || brd.refresh !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: playing=%0b refresh=%0b want 0 0", playing, brd.refresh);
    end
    n_checks++; if (brd.piece_type !== 3'd0 || next_type !== 3'd0) begin
      n_fail++; $display("FAIL mid_reset_types: type=%0d next=%0d want 0 0", brd.piece_type, next_type);
    end
    brd.refresh_done = 1; cyc(); brd.refresh_done = 0;
    cyc();
    n_checks++; if (playing !== 1'b0 || brd.piece_type !== 3'd0 || next_type !== 3'd0) begin
      n_fail++; $display("FAIL stray_refresh_done: playing=%0b type=%0d next=%0d want 0 0 0", playing, brd.piece_type, next_type);
    end
    $display("test_reset_in_wait_ref: playing=%0b", playing);
  endtask

`ifdef HARD_DROP_EN
  task automatic test_hard_drop();
    rstn = 0; clear_inputs(); cyc(); rstn = 1;
    brd.edrop = 1;
    start = 1; cyc(); start = 0;
    cyc();
    btn_down = 1; cyc(); cyc(); btn_down = 0;
    n_checks++; if (brd.y !== 5'd2) begin n_fail++; $display("FAIL hard_setup: y=%0d want 2", brd.y); end
    btn_hard = 1; cyc(); btn_hard = 0;
    n_checks++; if (brd.y !== 5'd2) begin n_fail++; $display("FAIL hard_enter: y=%0d want 2", brd.y); end
    btn_l = 1; brd.el = 1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      n_checks++; if (brd.y !== 5'(2 + i)) begin n_fail++; $display("FAIL hard_step%0d: y=%0d want %0d", i, brd.y, 2 + i); end
    end
    btn_l = 0;
    brd.edrop = 0;
    cyc();
    n_checks++; if (brd.refresh !== 1'b1 || brd.y !== 5'd7 || brd.x !== 5'd3) begin
      n_fail++; $display("FAIL hard_lock: refresh=%0b y=%0d x=%0d want 1 7 3", brd.refresh, brd.y, brd.x);
    end
    $display("test_hard_drop: y=%0d refresh=%0b", brd.y, brd.refresh);
  endtask
`endif

  initial begin
    rstn = 0;
    clear_inputs();
    test_reset();
    test_gravity();
    test_moves();
    test_down_priority();
    test_rotate();
    test_lock();
    test_game_over();
    test_reset_in_wait_ref();
`ifdef HARD_DROP_EN
    test_hard_drop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
